// File: rtl/pll_lock_supervisor.sv
// pll_lock_supervisor
//
// Sits behind the iCE40 PLL wrapper, clocked by the PLL output clock.
// It synchronises the raw PLL lock flag and holds downstream logic in reset
// until lock has been stable for LOCK_WAIT cycles. It records lock losses
// and generates NUM_CH phase-aligned one-cycle clock-enable strobes, each
// with its own runtime divisor.
//
// Ports
//   clock_in    PLL output clock; all logic on its rising edge
//   reset       synchronous, active-high reset
//   locked      raw PLL LOCK, asynchronous to clock_in
//   div         per-channel divisors, channel n at [n*DIV_W +: DIV_W]
//   clear_flags one-cycle pulse clearing lost_flag and loss_count
//   sys_reset   registered active-high reset for downstream logic
//   ready       high while running; always ~sys_reset
//   strobe      per-channel one-cycle clock-enable pulses
//   lost_flag   sticky, set on a lock loss from RUN
//   loss_count  saturating count of lock losses from RUN
module pll_lock_supervisor #(
    parameter int LOCK_WAIT = 1024,
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int CNT_W     = 8
) (
    input  logic                      clock_in,
    input  logic                      reset,
    input  logic                      locked,
    input  logic [NUM_CH*DIV_W-1:0]   div,
    input  logic                      clear_flags,
    output logic                      sys_reset,
    output logic                      ready,
    output logic [NUM_CH-1:0]         strobe,
    output logic                      lost_flag,
    output logic [CNT_W-1:0]          loss_count
);

    localparam int SW = $clog2(LOCK_WAIT) + 1;
    localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_WAIT - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        RUN       = 2'd1,
        LOST      = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic            run_next;
    logic            lock_p0;
    logic            lock_s;
    logic [SW-1:0]   stab_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Stage p0 -> lock_s: two-flop synchroniser, the only sampler of locked
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lock_p0 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            lock_p0 <= locked;
            lock_s  <= lock_p0;
        end
    end

    // Supervisor state machine
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state <= WAIT_LOCK;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: if (lock_s && stab_cnt == STAB_LAST) state_next = RUN;
            RUN:       if (!lock_s) state_next = LOST;
            LOST:      state_next = WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
        // Registered outputs follow the state being entered, so sys_reset
        // and the strobe channels change on the same edge as the state.
        run_next = (state_next == RUN);
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            stab_cnt <= '0;
        end else begin
            case (state)
                WAIT_LOCK: stab_cnt <= lock_s ? stab_cnt + SW'(1) : '0;
                LOST:      stab_cnt <= '0;
                default:   stab_cnt <= stab_cnt;
            endcase
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset) begin
            sys_reset <= 1'b1;
        end else begin
            sys_reset <= !run_next;
        end
    end

    assign ready = ~sys_reset;

    // Loss bookkeeping happens during the LOST cycle itself, so a clear
    // arriving in that same cycle is applied first and the loss still counts.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            lost_flag  <= 1'b0;
            loss_count <= '0;
        end else if (state == LOST) begin
            lost_flag  <= 1'b1;
            loss_count <= sat_inc(clear_flags ? '0 : loss_count);
        end else if (clear_flags) begin
            lost_flag  <= 1'b0;
            loss_count <= '0;
        end
    end

    // Strobe channels: ctr holds the position that the next RUN edge will
    // evaluate, so every entry to RUN starts each channel at position 0.
    for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
        logic [DIV_W-1:0] ctr;
        logic [DIV_W-1:0] dl;
        logic [DIV_W-1:0] div_n;
        logic [DIV_W-1:0] last;
        logic             strobe_r;

        assign div_n     = div[n*DIV_W +: DIV_W];
        assign last      = dl - DIV_W'(1);
        assign strobe[n] = strobe_r;

        always_ff @(posedge clock_in) begin
            if (reset || !run_next) begin
                ctr      <= '0;
                dl       <= div_n;
                strobe_r <= 1'b0;
            end else if (dl == '0) begin
                // Disabled channel keeps watching div so it can start cleanly.
                ctr      <= '0;
                dl       <= div_n;
                strobe_r <= 1'b0;
            end else if (ctr == last) begin
                // Divisor changes are only picked up here, at the wrap.
                ctr      <= '0;
                dl       <= div_n;
                strobe_r <= 1'b1;
            end else begin
                ctr      <= ctr + DIV_W'(1);
                strobe_r <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
module tb_pll_lock_supervisor;

    localparam int LOCK_WAIT = 16;
    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 8;
    localparam int CNT_W     = 2;

    logic                    clock_in;
    logic                    reset;
    logic                    locked;
    logic [NUM_CH*DIV_W-1:0] div;
    logic                    clear_flags;
    logic                    sys_reset;
    logic                    ready;
    logic [NUM_CH-1:0]       strobe;
    logic                    lost_flag;
    logic [CNT_W-1:0]        loss_count;

    int checks   = 0;
    int failures = 0;

    pll_lock_supervisor #(
        .LOCK_WAIT (LOCK_WAIT),
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .CNT_W     (CNT_W)
    ) dut (
        .clock_in    (clock_in),
        .reset       (reset),
        .locked      (locked),
        .div         (div),
        .clear_flags (clear_flags),
        .sys_reset   (sys_reset),
        .ready       (ready),
        .strobe      (strobe),
        .lost_flag   (lost_flag),
        .loss_count  (loss_count)
    );

    initial clock_in = 1'b0;
    always #5 clock_in = ~clock_in;

    typedef struct {
        bit clr;
        int exp_before;
        int exp_count;
        bit exp_lost;
    } loss_vec_t;

    loss_vec_t tbl [6];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock_in);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        bit exp0;
        bit exp1;

        tbl[0] = '{clr: 1'b0, exp_before: 0, exp_count: 1, exp_lost: 1'b1};
        tbl[1] = '{clr: 1'b0, exp_before: 1, exp_count: 2, exp_lost: 1'b1};
        tbl[2] = '{clr: 1'b0, exp_before: 2, exp_count: 3, exp_lost: 1'b1};
        tbl[3] = '{clr: 1'b0, exp_before: 3, exp_count: 3, exp_lost: 1'b1};
        tbl[4] = '{clr: 1'b0, exp_before: 3, exp_count: 3, exp_lost: 1'b1};
        tbl[5] = '{clr: 1'b1, exp_before: 3, exp_count: 1, exp_lost: 1'b1};

        // Reset values
        reset       = 1'b1;
        locked      = 1'b0;
        clear_flags = 1'b0;
        div         = {8'd6, 8'd3};
        tick(3);
        chk("rst_sys_reset", sys_reset, 1);
        chk("rst_ready", ready, 0);
        chk("rst_strobe", strobe, 0);
        chk("rst_lost_flag", lost_flag, 0);
        chk("rst_loss_count", loss_count, 0);

        // Lock acquisition: locked rises after edge 5, RUN at edge 23
        reset = 1'b0;
        tick(5);
        locked = 1'b1;
        tick(17);
        chk("acq_edge22_sys_reset", sys_reset, 1);
        chk("acq_edge22_strobe", strobe, 0);
        tick(1);
        chk("acq_edge23_sys_reset", sys_reset, 0);
        chk("acq_edge23_ready", ready, 1);
        chk("acq_loss_count", loss_count, 0);

        // Strobes with div {3,6}; div[0] changed to 5 mid-period at m=12
        for (int m = 0; m < 26; m++) begin
            exp0 = (m <= 14) ? (m % 3 == 2) : ((m - 14) % 5 == 0);
            exp1 = (m % 6 == 5);
            chk($sformatf("strobe_div_m%0d", m), strobe, {exp1, exp0});
            if (m == 12) div[7:0] = 8'd5;
            tick(1);
        end

        // Lock loss for 3 cycles, then restore
        locked = 1'b0;
        tick(2);
        chk("loss_k1_sys_reset", sys_reset, 0);
        tick(1);
        chk("loss_k2_sys_reset", sys_reset, 1);
        chk("loss_k2_ready", ready, 0);
        chk("loss_k2_strobe", strobe, 0);
        chk("loss_k2_lost_flag", lost_flag, 0);
        locked = 1'b1;
        tick(1);
        chk("loss_k3_lost_flag", lost_flag, 1);
        chk("loss_k3_loss_count", loss_count, 1);
        div = {8'd0, 8'd1};
        tick(16);
        chk("relock_early_sys_reset", sys_reset, 1);
        chk("relock_early_strobe", strobe, 0);
        tick(1);
        chk("relock_ready", ready, 1);
        chk("relock_strobe", strobe, 2'b01);
        chk("relock_lost_flag", lost_flag, 1);

        // Channel 1 disabled, then enabled with divisor 1
        for (int m = 1; m <= 3; m++) begin
            tick(1);
            chk($sformatf("div0_silent_m%0d", m), strobe, 2'b01);
        end
        div[15:8] = 8'd1;
        tick(1);
        chk("div1_reload", strobe, 2'b01);
        tick(1);
        chk("div1_on_a", strobe, 2'b11);
        tick(1);
        chk("div1_on_b", strobe, 2'b11);

        // clear_flags outside LOST clears immediately
        clear_flags = 1'b1;
        tick(1);
        clear_flags = 1'b0;
        chk("clear_lost_flag", lost_flag, 0);
        chk("clear_loss_count", loss_count, 0);

        // Saturating loss counter, clear coincident with the 6th loss
        for (int i = 0; i < 6; i++) begin
            locked = 1'b0;
            tick(3);
            chk($sformatf("sat%0d_lost_sys_reset", i), sys_reset, 1);
            chk($sformatf("sat%0d_before", i), loss_count, tbl[i].exp_before);
            if (tbl[i].clr) clear_flags = 1'b1;
            locked = 1'b1;
            tick(1);
            clear_flags = 1'b0;
            chk($sformatf("sat%0d_count", i), loss_count, tbl[i].exp_count);
            chk($sformatf("sat%0d_lost", i), lost_flag, tbl[i].exp_lost);
            tick(16);
            chk($sformatf("sat%0d_wait", i), sys_reset, 1);
            tick(1);
            chk($sformatf("sat%0d_ready", i), ready, 1);
        end

        // Reset while running, mid strobe activity
        tick(2);
        chk("run_strobe_before_reset", strobe, 2'b11);
        reset = 1'b1;
        tick(1);
        chk("midrun_rst_sys_reset", sys_reset, 1);
        chk("midrun_rst_ready", ready, 0);
        chk("midrun_rst_strobe", strobe, 0);
        chk("midrun_rst_lost_flag", lost_flag, 0);
        chk("midrun_rst_loss_count", loss_count, 0);
        reset = 1'b0;
        tick(17);
        chk("post_rst_wait", sys_reset, 1);
        tick(1);
        chk("post_rst_ready", ready, 1);

        // Periodic single-cycle glitches never allow RUN
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        for (int i = 0; i < 60; i++) begin
            locked = (i % 10 != 9);
            tick(1);
            chk($sformatf("glitch_c%0d_sys_reset", i), sys_reset, 1);
        end
        chk("glitch_lost_flag", lost_flag, 0);
        chk("glitch_loss_count", loss_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
